bram_arb: RTL and testbench
===========================

BRAM_ARB -- requirements
Module: bram_arb

Interface
REQ-001 Parameter N_ROW, default 3: number of valid row (x) indices in the attached byte RAM.
REQ-002 Parameter N_COL, default 3: number of valid column (y) indices in the attached byte RAM.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 p_req  in  1  request from port p, for p in {a,b}; held until granted.
REQ-007 p_we  in  1  port p operation: 1 = write, 0 = read.
REQ-008 p_addr  in  6  port p address; [5:3] = x (row), [2:0] = y (col).
REQ-009 p_wdata  in  8  port p write data.
REQ-010 p_gnt  out  1  port p request accepted this cycle (combinational).
REQ-011 p_rvalid  out  1  port p read data valid on rdata (registered).
REQ-012 rdata  out  8  shared read data; driven straight from bram_data_out.
REQ-013 bram_addr_in / bram_wr_en / bram_data_in  out  6/1/8  RAM write port.
REQ-014 bram_addr_out / bram_rd_en  out  6/1  RAM read port; bram_data_out  in  8, valid 1 cycle after bram_rd_en.
REQ-015 err  out  1  out-of-range access pulse; present only with BRAM_ARB_ADDR_CHK_EN.

Function
REQ-016 Write and read channels SHALL be arbitrated independently: at most 1 write grant and at most 1 read grant per cycle; one write and one read may be granted in the same cycle.
REQ-017 Uncontested request (only one port requesting that op type) SHALL be granted the same cycle it is asserted.
REQ-018 Contested request (both ports, same op type) SHALL be granted to that channel's priority pointer; the pointer then flips to the loser.
REQ-019 Uncontested grants SHALL NOT change the priority pointer.
REQ-020 A granted write SHALL drive bram_wr_en=1, bram_addr_in=p_addr, bram_data_in=p_wdata in the grant cycle; all are 0 otherwise.
REQ-021 A granted read SHALL drive bram_rd_en=1, bram_addr_out=p_addr in the grant cycle; p_rvalid SHALL be 1 exactly in the next cycle, with rdata valid.
REQ-022 A read and a write to the same address granted in the same cycle SHALL return the old (pre-write) data.
REQ-023 Back-to-back reads SHALL sustain 1 read per cycle; a_rvalid and b_rvalid SHALL never both be 1.
REQ-024 Requests with p_req=0 SHALL be ignored regardless of p_we/p_addr values.

Reset
REQ-025 While rst=1: all gnt, rvalid, bram_* enables and err SHALL be 0; both priority pointers SHALL be set to port a.
REQ-026 A read granted in the cycle before rst is asserted SHALL NOT produce rvalid; in-flight read results are discarded.
REQ-027 The first cycle after rst deasserts SHALL arbitrate normally, with no extra dead cycles.

Configuration
REQ-028 With BRAM_ARB_ADDR_CHK_EN defined: a request with x >= N_ROW or y >= N_COL SHALL still be granted, but bram_wr_en/bram_rd_en SHALL be suppressed, no rvalid SHALL follow, and err SHALL pulse for 1 cycle (registered, cycle after grant).
REQ-029 Without BRAM_ARB_ADDR_CHK_EN: the err port is absent and all addresses are passed through unchecked.

Structure
REQ-030 Shared package bram_arb_pkg SHALL hold: ADDR_W=6, DATA_W=8, the X/Y field widths (3/3), and a port-id enum {PORT_A, PORT_B}.
REQ-031 Sub-module rr_arb2 (2-requester round-robin, pointer plus grant logic) SHALL be instantiated twice, once per channel.

Verification
REQ-032 a write addr 0x09 data 0x5A, then a read 0x09 -> a_gnt same cycle both times; a_rvalid 1 cycle after read grant with rdata=0x5A.
REQ-033 a and b both write, held 4 cycles, after reset -> grants alternate a,b,a,b; a_gnt and b_gnt never both 1 on the write channel.
REQ-034 Same cycle: a writes 0x12 <- 0x77 (old 0x11), b reads 0x12 -> both granted; b_rvalid next cycle with rdata=0x11.
REQ-035 b read granted, rst asserted next cycle -> b_rvalid stays 0; both pointers = a after reset.
REQ-036 With BRAM_ARB_ADDR_CHK_EN: a reads addr 0x1C (x=3) -> a_gnt=1, bram_rd_en=0, err=1 next cycle, a_rvalid stays 0; without the macro, bram_rd_en=1.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the dual-port byte-RAM arbiter.
// The optional range check is enabled by defining BRAM_ARB_ADDR_CHK_EN.
package bram_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int X_W    = 3;
    localparam int Y_W    = 3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    // Address is in range when row field < n_row and column field < n_col.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                     input int n_row,
                                     input int n_col);
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        x = addr[ADDR_W-1:Y_W];
        y = addr[Y_W-1:0];
        return (int'(x) < n_row) && (int'(y) < n_col);
    endfunction

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-requester round-robin arbiter: the priority pointer only moves on a
// contested cycle, and then it moves to the requester that lost.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_id_e ptr_r;
    port_id_e ptr_nxt_s;

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PORT_A;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Next pointer: flip to the loser only when both ports requested.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (req == 2'b11) begin
            ptr_nxt_s = (ptr_r == PORT_A) ? PORT_B : PORT_A;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            gnt = 2'b00;
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr_r == PORT_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/bram_arb.sv
// Arbitrates ports a and b onto a byte RAM with independent write and read
// channels. Define BRAM_ARB_ADDR_CHK_EN to add the out-of-range check and err.
module bram_arb
    import bram_arb_pkg::*;
#(
    parameter int N_ROW = 3,
    parameter int N_COL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_addr_in,
    output logic              bram_wr_en,
    output logic [DATA_W-1:0] bram_data_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_rd_en,
    input  logic [DATA_W-1:0] bram_data_out
`ifdef BRAM_ARB_ADDR_CHK_EN
    ,
    output logic              err
`endif
);

    logic [1:0]        wr_req_s;
    logic [1:0]        rd_req_s;
    logic [1:0]        wr_gnt_s;
    logic [1:0]        rd_gnt_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              a_rvalid_r;
    logic              b_rvalid_r;

    assign wr_req_s = {b_req & b_we,  a_req & a_we};
    assign rd_req_s = {b_req & ~b_we, a_req & ~a_we};

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req_s),
        .gnt (wr_gnt_s)
    );

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req_s),
        .gnt (rd_gnt_s)
    );

    assign wr_addr_s = wr_gnt_s[1] ? b_addr  : a_addr;
    assign wr_data_s = wr_gnt_s[1] ? b_wdata : a_wdata;
    assign rd_addr_s = rd_gnt_s[1] ? b_addr  : a_addr;

`ifdef BRAM_ARB_ADDR_CHK_EN
    logic err_r;

    assign wr_ok_s = addr_ok(wr_addr_s, N_ROW, N_COL);
    assign rd_ok_s = addr_ok(rd_addr_s, N_ROW, N_COL);

    // A granted but out-of-range access flags err on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= ((|wr_gnt_s) & ~wr_ok_s) | ((|rd_gnt_s) & ~rd_ok_s);
        end
    end

    assign err = err_r & ~rst;
`else
    logic unused_range_s;

    assign wr_ok_s        = 1'b1;
    assign rd_ok_s        = 1'b1;
    assign unused_range_s = addr_ok(wr_addr_s, N_ROW, N_COL) ^ addr_ok(rd_addr_s, N_ROW, N_COL);
`endif

    assign wr_fire_s = (|wr_gnt_s) & wr_ok_s;
    assign rd_fire_s = (|rd_gnt_s) & rd_ok_s;

    // Grants and RAM port drive; address/data buses are zero when idle.
    always_comb begin
        a_gnt         = wr_gnt_s[0] | rd_gnt_s[0];
        b_gnt         = wr_gnt_s[1] | rd_gnt_s[1];
        bram_wr_en    = wr_fire_s;
        bram_addr_in  = wr_fire_s ? wr_addr_s : {ADDR_W{1'b0}};
        bram_data_in  = wr_fire_s ? wr_data_s : {DATA_W{1'b0}};
        bram_rd_en    = rd_fire_s;
        bram_addr_out = rd_fire_s ? rd_addr_s : {ADDR_W{1'b0}};
    end

    // Read-valid tracks a performed read by one cycle, tagged with its port.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rvalid_r <= rd_gnt_s[0] & rd_ok_s;
            b_rvalid_r <= rd_gnt_s[1] & rd_ok_s;
        end
    end

    // Masking with rst drops a result whose read was issued just before reset.
    assign a_rvalid = a_rvalid_r & ~rst;
    assign b_rvalid = b_rvalid_r & ~rst;
    assign rdata    = bram_data_out;

endmodule

// File: tb/tb_bram_arb.sv
// Directed self-checking bench for bram_arb with a 1-cycle-latency byte RAM
// model attached to the RAM ports.
module tb_bram_arb;
    import bram_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] bram_addr_in, bram_addr_out;
    logic              bram_wr_en, bram_rd_en;
    logic [DATA_W-1:0] bram_data_in;
    logic [DATA_W-1:0] bram_data_out;
`ifdef BRAM_ARB_ADDR_CHK_EN
    logic              err;
`endif

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bram_arb #(.N_ROW(3), .N_COL(3)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .bram_addr_in(bram_addr_in), .bram_wr_en(bram_wr_en), .bram_data_in(bram_data_in),
        .bram_addr_out(bram_addr_out), .bram_rd_en(bram_rd_en), .bram_data_out(bram_data_out)
`ifdef BRAM_ARB_ADDR_CHK_EN
        , .err(err)
`endif
    );

    // Byte RAM model: read returns pre-write data when both hit the same edge.
    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_addr_in] <= bram_data_in;
        if (bram_rd_en) bram_data_out <= mem[bram_addr_out];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr[ADDR_W-1:0]; a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr[ADDR_W-1:0]; b_wdata = wd;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_a [0:3];
        exp_a[0] = 2'b01; exp_a[1] = 2'b10; exp_a[2] = 2'b01; exp_a[3] = 2'b10;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        bram_data_out = 8'h00;
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        step(); step();

        // Requests are ignored while reset is held.
        drive_a(1'b1, 1'b1, 8'h09, 8'h5A);
        drive_b(1'b1, 1'b0, 8'h09, 8'h00);
        #1;
        check("rst_a_gnt", a_gnt, 1'b0);
        check("rst_b_gnt", b_gnt, 1'b0);
        check("rst_wr_en", bram_wr_en, 1'b0);
        check("rst_rd_en", bram_rd_en, 1'b0);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);

        // Write then read 0x09; first cycle out of reset arbitrates normally.
        step(); rst = 1'b0;
        #1;
        check("wr_a_gnt", a_gnt, 1'b1);
        check("wr_en", bram_wr_en, 1'b1);
        check("wr_addr", bram_addr_in, 8'h09);
        check("wr_data", bram_data_in, 8'h5A);
        step(); drive_a(1'b1, 1'b0, 8'h09, 8'h00);
        #1;
        check("rd_a_gnt", a_gnt, 1'b1);
        check("rd_en", bram_rd_en, 1'b1);
        check("rd_addr", bram_addr_out, 8'h09);
        check("rd_no_wr", bram_wr_en, 1'b0);
        step(); drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd_a_rvalid", a_rvalid, 1'b1);
        check("rd_rdata", rdata, 8'h5A);
        check("rd_b_rvalid", b_rvalid, 1'b0);
        step();
        check("rd_a_rvalid_drop", a_rvalid, 1'b0);

        // Contested writes after reset alternate a, b, a, b.
        rst = 1'b1; step(); rst = 1'b0;
        drive_a(1'b1, 1'b1, 8'h00, 8'h01);
        drive_b(1'b1, 1'b1, 8'h01, 8'h02);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt_gnt%0d", i), {b_gnt, a_gnt}, exp_a[i]);
            check($sformatf("alt_addr%0d", i), bram_addr_in, exp_a[i][1] ? 8'h01 : 8'h00);
            step();
        end
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);

        // Same-cycle write and read to 0x12 returns the old byte.
        drive_a(1'b1, 1'b1, 8'h12, 8'h11);
        step();
        drive_a(1'b1, 1'b1, 8'h12, 8'h77);
        drive_b(1'b1, 1'b0, 8'h12, 8'h00);
        #1;
        check("rw_gnt", {b_gnt, a_gnt}, 2'b11);
        check("rw_en", {bram_rd_en, bram_wr_en}, 2'b11);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rw_b_rvalid", b_rvalid, 1'b1);
        check("rw_old_data", rdata, 8'h11);
        check("rw_a_rvalid", a_rvalid, 1'b0);

        // Contested back-to-back reads: a first, then b; one rvalid per cycle.
        step();
        drive_a(1'b1, 1'b0, 8'h12, 8'h00);
        drive_b(1'b1, 1'b0, 8'h09, 8'h00);
        #1;
        check("rr_gnt0", {b_gnt, a_gnt}, 2'b01);
        check("rr_addr0", bram_addr_out, 8'h12);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rr_gnt1", {b_gnt, a_gnt}, 2'b10);
        check("rr_addr1", bram_addr_out, 8'h09);
        check("rr_rv1", {b_rvalid, a_rvalid}, 2'b01);
        check("rr_data1", rdata, 8'h77);
        step();
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rr_rv2", {b_rvalid, a_rvalid}, 2'b10);
        check("rr_data2", rdata, 8'h5A);

        // Move both pointers to b, then a read is cut off by reset.
        step();
        drive_a(1'b1, 1'b1, 8'h00, 8'h03);
        drive_b(1'b1, 1'b1, 8'h01, 8'h04);
        #1;
        check("pre_wr_gnt", {b_gnt, a_gnt}, 2'b01);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b1, 1'b0, 8'h09, 8'h00);
        #1;
        check("cut_b_gnt", b_gnt, 1'b1);
        step();
        rst = 1'b1;
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("cut_b_rvalid0", b_rvalid, 1'b0);
        step();
        check("cut_b_rvalid1", b_rvalid, 1'b0);
        rst = 1'b0;
        drive_a(1'b1, 1'b1, 8'h00, 8'h05);
        drive_b(1'b1, 1'b1, 8'h01, 8'h06);
        #1;
        check("post_wr_ptr", {b_gnt, a_gnt}, 2'b01);
        step();
        drive_a(1'b1, 1'b0, 8'h00, 8'h00);
        drive_b(1'b1, 1'b0, 8'h01, 8'h00);
        #1;
        check("post_rd_ptr", {b_gnt, a_gnt}, 2'b01);
        step();

        // Idle request lines ignore we/addr.
        drive_a(1'b0, 1'b1, 8'h09, 8'hFF);
        drive_b(1'b0, 1'b0, 8'h12, 8'h00);
        #1;
        check("idle_gnt", {b_gnt, a_gnt}, 2'b00);
        check("idle_en", {bram_rd_en, bram_wr_en}, 2'b00);
        step();
        step();

        // Out-of-range read 0x1C (x=3).
        drive_a(1'b1, 1'b0, 8'h1C, 8'h00);
        #1;
        check("oor_a_gnt", a_gnt, 1'b1);
`ifdef BRAM_ARB_ADDR_CHK_EN
        check("oor_rd_en", bram_rd_en, 1'b0);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("oor_err", err, 1'b1);
        check("oor_rvalid", a_rvalid, 1'b0);
        step();
        check("oor_err_pulse", err, 1'b0);
`else
        check("oor_rd_en", bram_rd_en, 1'b1);
        check("oor_addr", bram_addr_out, 8'h1C);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("oor_rvalid", a_rvalid, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
